pci_mem_target: RTL and testbench

PCI_MEM_TARGET -- requirements
Module: pci_mem_target

---
 rtl/pci_mem_pkg.sv | 14 +
 rtl/pci_mem_array.sv | 27 ++
 rtl/pci_mem_target.sv | 140 ++++++++++++++
 tb/tb_pci_mem_target.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pci_mem_pkg.sv
// Shared command codes and FSM encoding for the PCI memory target.
package pci_mem_pkg;

   localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
   localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WRITE  = 2'd1,
      READ   = 2'd2,
      IGNORE = 2'd3
   } state_e;

endpackage

// File: rtl/pci_mem_array.sv
// DEPTH x 32 word store with per-byte write enables and one asynchronous read port.
module pci_mem_array
   import pci_mem_pkg::*;
#(
   parameter int DEPTH = 10,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic [3:0]    we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [31:0]   wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem_q [DEPTH];

   // Contents deliberately have no reset; only enabled byte lanes change.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (we_i[i]) mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pci_mem_target.sv
// PCI memory target: decodes an address phase, then services write/read bursts
// from a word pointer into pci_mem_array; unmatched cycles are ignored.
module pci_mem_target
   import pci_mem_pkg::*;
#(
   parameter int          DEPTH     = 10,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter bit          WRAP_EN   = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        FRAME,
   input  logic        IRDY,
   input  logic        TRDY,
   input  logic [3:0]  C_BE,
   input  logic [31:0] AD_in,
   output logic [31:0] AD_out,
   output logic        AD_oe,
   output logic        hit,
   output logic [1:0]  state_dbg_o
);

   localparam int            PW   = $clog2(DEPTH);
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

   state_e        state_q, state_d;
   logic [PW-1:0] ptr_q, ptr_d;
   logic          hit_q, hit_d;
   logic          ad_oe_q, ad_oe_d;
   logic          done_q, done_d;
   logic          frame_q;
   logic [31:0]   ad_out_q, ad_out_d;
   logic [3:0]    we;
   logic [3:0]    we_gated;
   logic [31:0]   rd_data;

   logic [31:0] offset;
   logic [31:0] word_idx;
   logic        addr_hit;
   logic        phase_done;
   logic        start;

   assign offset     = AD_in - BASE_ADDR;
   assign word_idx   = {2'b00, offset[31:2]};
   assign addr_hit   = (AD_in >= BASE_ADDR) && (word_idx < 32'(DEPTH));
   assign phase_done = !IRDY && !TRDY;
   // Only a FRAME falling edge starts a transaction, so a burst aborted by
   // reset is not re-decoded from its data phases.
   assign start      = (state_q == IDLE) && !FRAME && frame_q;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      hit_d   = hit_q;
      ad_oe_d = ad_oe_q;
      done_d  = done_q;
      we      = 4'b0000;
      case (state_q)
         IDLE: begin
            hit_d   = 1'b0;
            ad_oe_d = 1'b0;
            if (start) begin
               done_d = 1'b0;
               ptr_d  = word_idx[PW-1:0];
               if (addr_hit && C_BE == CMD_MEM_WRITE) begin
                  state_d = WRITE;
                  hit_d   = 1'b1;
               end else if (addr_hit && C_BE == CMD_MEM_READ) begin
                  state_d = READ;
                  hit_d   = 1'b1;
               end else begin
                  state_d = IGNORE;
               end
            end
         end
         WRITE, READ: begin
            if (state_q == READ) ad_oe_d = 1'b1;
            if (phase_done) begin
               if (state_q == WRITE && !done_q) we = ~C_BE;
               // Saturating mode flags the last word so later writes drop.
               if (ptr_q == LAST) begin
                  if (WRAP_EN) ptr_d = '0;
                  else         done_d = 1'b1;
               end else begin
                  ptr_d = ptr_q + PW'(1);
               end
               if (FRAME) begin
                  state_d = IDLE;
                  hit_d   = 1'b0;
                  ad_oe_d = 1'b0;
               end
            end
         end
         IGNORE: begin
            hit_d   = 1'b0;
            ad_oe_d = 1'b0;
            if (FRAME && IRDY) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign we_gated = rst ? 4'b0000 : we;
   assign ad_out_d = (state_d == READ) ? rd_data : ad_out_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         hit_q    <= 1'b0;
         ad_oe_q  <= 1'b0;
         done_q   <= 1'b0;
         frame_q  <= 1'b0;
         ad_out_q <= 32'h0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         hit_q    <= hit_d;
         ad_oe_q  <= ad_oe_d;
         done_q   <= done_d;
         frame_q  <= FRAME;
         ad_out_q <= ad_out_d;
      end
   end

   pci_mem_array #(.DEPTH(DEPTH), .AW(PW)) u_array (
      .clk     (clk),
      .we_i    (we_gated),
      .waddr_i (ptr_q),
      .wdata_i (AD_in),
      .raddr_i (ptr_d),
      .rdata_o (rd_data)
   );

   assign AD_out      = ad_out_q;
   assign AD_oe       = ad_oe_q;
   assign hit         = hit_q;
   assign state_dbg_o = state_q;

endmodule

// File: tb/tb_pci_mem_target.sv
// Bench for pci_mem_target: wrapping and saturating instances on one shared bus.
module tb_pci_mem_target;

   localparam logic [31:0] BASE = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        rst;
   logic        frame, irdy, trdy;
   logic [3:0]  cbe;
   logic [31:0] ad;

   logic [31:0] ad_out, ad_out_nw;
   logic        ad_oe, ad_oe_nw, hit, hit_nw;
   logic [1:0]  st, st_nw;

   int n_chk  = 0;
   int n_fail = 0;

   logic [31:0] exp_q[$];
   logic [31:0] exp_nw_q[$];
   logic [31:0] wr_q[$];

   typedef struct {
      logic        frame, irdy, trdy;
      logic [3:0]  cbe;
      logic [31:0] ad;
      logic        exp_hit, exp_oe, chk_dat;
      logic [31:0] exp_dat;
   } vec_t;

   vec_t vecs[$];

   pci_mem_target #(.DEPTH(10), .BASE_ADDR(BASE), .WRAP_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .FRAME(frame), .IRDY(irdy), .TRDY(trdy),
      .C_BE(cbe), .AD_in(ad), .AD_out(ad_out), .AD_oe(ad_oe), .hit(hit),
      .state_dbg_o(st)
   );

   pci_mem_target #(.DEPTH(10), .BASE_ADDR(BASE), .WRAP_EN(1'b0)) dut_nw (
      .clk(clk), .rst(rst), .FRAME(frame), .IRDY(irdy), .TRDY(trdy),
      .C_BE(cbe), .AD_in(ad), .AD_out(ad_out_nw), .AD_oe(ad_oe_nw), .hit(hit_nw),
      .state_dbg_o(st_nw)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic f, input logic i, input logic t,
                        input logic [3:0] c, input logic [31:0] a);
      frame = f;
      irdy  = i;
      trdy  = t;
      cbe   = c;
      ad    = a;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_ctl(input string name, input logic exp_hit, input logic exp_oe);
      chk({name, " hit"}, {31'd0, hit}, {31'd0, exp_hit});
      chk({name, " oe"}, {31'd0, ad_oe}, {31'd0, exp_oe});
      chk({name, " hit_nw"}, {31'd0, hit_nw}, {31'd0, exp_hit});
      chk({name, " oe_nw"}, {31'd0, ad_oe_nw}, {31'd0, exp_oe});
   endtask

   task automatic write_burst(input logic [31:0] addr, input logic [3:0] be);
      int n;
      n = wr_q.size();
      drive(1'b0, 1'b1, 1'b1, 4'b0111, addr);
      step();
      chk_ctl("wr addr", 1'b1, 1'b0);
      for (int k = 0; k < n; k++) begin
         drive(k == n - 1, 1'b0, 1'b0, be, wr_q[k]);
         step();
         chk_ctl($sformatf("wr phase %0d", k), k != n - 1, 1'b0);
      end
      wr_q.delete();
      drive(1'b1, 1'b1, 1'b1, 4'hF, 32'h0);
      step();
   endtask

   task automatic read_burst(input logic [31:0] addr, input int n);
      drive(1'b0, 1'b1, 1'b1, 4'b0110, addr);
      step();
      chk_ctl("rd turnaround", 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 4'hF, 32'h0);
      step();
      for (int k = 0; k < n; k++) begin
         chk_ctl($sformatf("rd phase %0d", k), 1'b1, 1'b1);
         chk($sformatf("rd data %0d", k), ad_out, exp_q.pop_front());
         chk($sformatf("rd data_nw %0d", k), ad_out_nw, exp_nw_q.pop_front());
         drive(k == n - 1, 1'b0, 1'b0, 4'hF, 32'h0);
         step();
      end
      chk_ctl("rd end", 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b1, 4'hF, 32'h0);
      step();
   endtask

   initial begin
      // Clock/reset
      rst = 1'b1;
      drive(1'b1, 1'b1, 1'b1, 4'hF, 32'h0);
      step();
      step();
      chk_ctl("reset", 1'b0, 1'b0);
      chk("reset ad_out", ad_out, 32'h0);
      chk("reset state", {30'd0, st}, 32'd0);
      rst = 1'b0;

      // Cycle table: inputs, then expected hit/oe/data after the edge.
      vecs.push_back('{1'b1, 1'b1, 1'b1, 4'hF, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0});
      vecs.push_back('{1'b0, 1'b1, 1'b1, 4'h7, BASE,          1'b1, 1'b0, 1'b0, 32'h0});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 4'h0, 32'd1,         1'b1, 1'b0, 1'b0, 32'h0});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 4'h0, 32'd2,         1'b1, 1'b0, 1'b0, 32'h0});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 4'h0, 32'd3,         1'b1, 1'b0, 1'b0, 32'h0});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 4'h0, 32'd4,         1'b0, 1'b0, 1'b0, 32'h0});
      vecs.push_back('{1'b1, 1'b1, 1'b1, 4'hF, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0});
      vecs.push_back('{1'b0, 1'b1, 1'b1, 4'h7, BASE + 32'd8,  1'b1, 1'b0, 1'b0, 32'h0});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 4'h0, 32'hAABBCCDD,  1'b0, 1'b0, 1'b0, 32'h0});
      vecs.push_back('{1'b0, 1'b1, 1'b1, 4'h7, BASE + 32'd8,  1'b1, 1'b0, 1'b0, 32'h0});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 4'hA, 32'h11223344,  1'b0, 1'b0, 1'b0, 32'h0});
      vecs.push_back('{1'b1, 1'b1, 1'b1, 4'hF, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0});
      vecs.push_back('{1'b0, 1'b1, 1'b1, 4'h6, BASE + 32'd4,  1'b1, 1'b0, 1'b0, 32'h0});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 4'hF, 32'h0,         1'b1, 1'b1, 1'b1, 32'd2});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 4'hF, 32'h0,         1'b1, 1'b1, 1'b1, 32'hAA22CC44});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 4'hF, 32'h0,         1'b1, 1'b1, 1'b1, 32'hAA22CC44});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 4'hF, 32'h0,         1'b1, 1'b1, 1'b1, 32'hAA22CC44});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 4'hF, 32'h0,         1'b1, 1'b1, 1'b1, 32'd4});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 4'hF, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0});
      vecs.push_back('{1'b1, 1'b1, 1'b1, 4'hF, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0});
      vecs.push_back('{1'b0, 1'b1, 1'b1, 4'h7, BASE + 32'd40, 1'b0, 1'b0, 1'b0, 32'h0});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 4'h0, 32'hDEADBEEF,  1'b0, 1'b0, 1'b0, 32'h0});
      vecs.push_back('{1'b1, 1'b1, 1'b1, 4'hF, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0});
      vecs.push_back('{1'b0, 1'b1, 1'b1, 4'h2, BASE,          1'b0, 1'b0, 1'b0, 32'h0});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 4'h0, 32'hDEADBEEF,  1'b0, 1'b0, 1'b0, 32'h0});
      vecs.push_back('{1'b1, 1'b1, 1'b1, 4'hF, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0});
      vecs.push_back('{1'b0, 1'b1, 1'b1, 4'h7, BASE - 32'd4,  1'b0, 1'b0, 1'b0, 32'h0});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 4'h0, 32'hDEADBEEF,  1'b0, 1'b0, 1'b0, 32'h0});
      vecs.push_back('{1'b1, 1'b1, 1'b1, 4'hF, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0});
      vecs.push_back('{1'b0, 1'b1, 1'b1, 4'h6, BASE,          1'b1, 1'b0, 1'b0, 32'h0});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 4'hF, 32'h0,         1'b1, 1'b1, 1'b1, 32'd1});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 4'hF, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0});
      vecs.push_back('{1'b1, 1'b1, 1'b1, 4'hF, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0});

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].frame, vecs[i].irdy, vecs[i].trdy, vecs[i].cbe, vecs[i].ad);
         step();
         chk_ctl($sformatf("vec %0d", i), vecs[i].exp_hit, vecs[i].exp_oe);
         if (vecs[i].chk_dat) begin
            chk($sformatf("vec %0d data", i), ad_out, vecs[i].exp_dat);
            chk($sformatf("vec %0d data_nw", i), ad_out_nw, vecs[i].exp_dat);
         end
      end

      // Burst crossing the last word: wraps on dut, saturates on dut_nw.
      wr_q = '{32'h90, 32'h91, 32'h92};
      write_burst(BASE + 32'd36, 4'h0);
      exp_q    = '{32'h90, 32'h91, 32'h92};
      exp_nw_q = '{32'h90, 32'h90, 32'h90};
      read_burst(BASE + 32'd36, 3);
      exp_q    = '{32'h91, 32'h92};
      exp_nw_q = '{32'd1, 32'd2};
      read_burst(BASE, 2);

      // Reset landing on the third write phase.
      wr_q = '{32'h66};
      write_burst(BASE + 32'd24, 4'h0);
      drive(1'b0, 1'b1, 1'b1, 4'b0111, BASE + 32'd16);
      step();
      chk_ctl("rst burst addr", 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 4'h0, 32'hA0);
      step();
      drive(1'b0, 1'b0, 1'b0, 4'h0, 32'hA1);
      step();
      chk_ctl("rst burst phase1", 1'b1, 1'b0);
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 4'h0, 32'hA2);
      step();
      rst = 1'b0;
      chk_ctl("mid-burst reset", 1'b0, 1'b0);
      chk("mid-burst reset ad_out", ad_out, 32'h0);
      chk("mid-burst reset ad_out_nw", ad_out_nw, 32'h0);
      chk("mid-burst reset state", {30'd0, st}, 32'd0);
      drive(1'b0, 1'b0, 1'b0, 4'h0, 32'hA3);
      step();
      chk_ctl("held frame after reset", 1'b0, 1'b0);
      chk("held frame state", {30'd0, st}, 32'd0);
      drive(1'b1, 1'b1, 1'b1, 4'hF, 32'h0);
      step();
      exp_q    = '{32'hA0, 32'hA1, 32'h66};
      exp_nw_q = '{32'hA0, 32'hA1, 32'h66};
      read_burst(BASE + 32'd16, 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
